pool2_flatten: RTL and testbench
================================

POOL2_FLATTEN -- requirements
Module: pool2_flatten

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter CH_NUM, default 16, number of pooled channels.
REQ-003 SHALL have parameter PIX_NUM, default 16, pooled pixels per channel (4x4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port data_in  input  DATA_W  pooled sample from the pool stage.
REQ-007 SHALL have port data_in_valid  input  1  data_in is valid this cycle.
REQ-008 SHALL have port in_channel  input  5  channel tag of data_in.
REQ-009 SHALL have port clear  input  1  synchronous abort; discards buffer contents and returns to FILL.
REQ-010 SHALL have port fc_data  output  DATA_W  flattened sample to the FC stage.
REQ-011 SHALL have port fc_index  output  8  flat index of fc_data, equal to channel*PIX_NUM+pixel.
REQ-012 SHALL have port fc_valid  output  1  fc_data/fc_index/fc_last are valid.
REQ-013 SHALL have port fc_ready  input  1  FC stage accepts the sample this cycle.
REQ-014 SHALL have port fc_last  output  1  asserted with index CH_NUM*PIX_NUM-1.
REQ-015 SHALL have port busy  output  1  high in states other than FILL.
REQ-016 SHALL have port err  output  1  sticky error flag.

Function
REQ-017 SHALL implement FSM states FILL, READ and SHOW.
REQ-018 SHALL, in FILL, write each valid sample with in_channel<CH_NUM to buffer address {in_channel[3:0], pix_cnt[in_channel]}, then increment that channel's 4-bit pix_cnt.
REQ-019 SHALL allow samples of different channels to interleave in any order; each channel keeps its own pix_cnt.
REQ-020 SHALL set the channel's done bit when its pix_cnt wraps from PIX_NUM-1 to 0.
REQ-021 SHALL ignore any sample that arrives for a channel whose done bit is set, and SHALL set err.
REQ-022 SHALL ignore any sample with in_channel>=CH_NUM, and SHALL set err.
REQ-023 SHALL move from FILL to READ in the cycle after all CH_NUM done bits are set, and SHALL reset rd_addr to 0.
REQ-024 SHALL drop every valid input received in READ or SHOW, and SHALL set err.
REQ-025 SHALL, in READ, issue a buffer read at rd_addr (1-cycle read latency) and move to SHOW.
REQ-026 SHALL, in SHOW, hold fc_valid=1 with fc_data, fc_index=rd_addr and fc_last stable until fc_ready=1.
REQ-027 SHALL, on a SHOW handshake with fc_last=0, increment rd_addr and go to READ, giving at most 1 sample per 2 cycles.
REQ-028 SHALL, on a SHOW handshake with fc_last=1, clear all pix_cnt and done bits and go to FILL; err is left unchanged.
REQ-029 SHALL treat fc_ready as a don't-care outside SHOW, and SHALL keep fc_valid=0 outside SHOW.
REQ-030 SHALL, on clear=1, return to FILL next cycle with all counters, done bits and fc_valid cleared and err also cleared; clear overrides all other events in that cycle.
REQ-031 SHALL, when a FILL write and the completion of the last done bit occur in the same cycle, commit the write before the state changes.

Reset
REQ-032 SHALL, while rst_n=0 at a clock edge, enter FILL and clear all pix_cnt, done bits and rd_addr to 0.
REQ-033 SHALL, while rst_n=0 at a clock edge, drive fc_valid=0, fc_last=0, fc_data=0, fc_index=0, busy=0 and err=0.
REQ-034 SHALL leave buffer RAM contents unreset; reset mid-drain abandons the frame.

Structure
REQ-035 SHALL take DATA_W, CH_NUM, PIX_NUM and the FSM state encoding from the shared cnn_pkg package.
REQ-036 SHALL instantiate one sub-module flat_buf_ram: CH_NUM*PIX_NUM x DATA_W, one write port and one synchronous read port.

Verification
REQ-037 SHALL verify: channels 0..15 each send 16 samples, value=ch*16+pix, fc_ready=1 -> 256 outputs with fc_data=fc_index=0..255, fc_last only at 255, busy back to 0.
REQ-038 SHALL verify: samples for channels 15 down to 0 round-robin interleaved -> output order is still by index 0..255 with correct values.
REQ-039 SHALL verify: fc_ready low for 5 cycles at index 37 -> fc_valid, fc_data and fc_index hold 37 throughout, with no loss or duplication.
REQ-040 SHALL verify: a 17th sample on channel 3, then in_channel=20, then input during SHOW -> each is dropped, err=1 and the output stream is unchanged.
REQ-041 SHALL verify: clear pulse at index 100 of the drain -> fc_valid=0 next cycle, state is FILL, err=0, and a new full frame drains correctly.
REQ-042 SHALL verify: rst_n low for 1 cycle mid-fill (channel 5, pixel 7) -> all outputs at reset values, and a subsequent full frame is correct.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants and the pool-to-FC flattener state encoding.
package cnn_pkg;

  localparam int unsigned CNN_DATA_W  = 16;
  localparam int unsigned CNN_CH_NUM  = 16;
  localparam int unsigned CNN_PIX_NUM = 16;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_READ = 2'd1,
    ST_SHOW = 2'd2
  } flat_state_t;

endpackage

// File: rtl/flat_buf_ram.sv
// Frame buffer for the flattener: one write port, one synchronous read port.
module flat_buf_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pool2_flatten.sv
// Collects a full frame of pooled samples per channel, then streams it to the
// FC stage in flat index order with a valid/ready handshake.
module pool2_flatten
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W  = CNN_DATA_W,
  parameter int unsigned CH_NUM  = CNN_CH_NUM,
  parameter int unsigned PIX_NUM = CNN_PIX_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic [4:0]        in_channel,
  input  logic              clear,
  output logic [DATA_W-1:0] fc_data,
  output logic [7:0]        fc_index,
  output logic              fc_valid,
  input  logic              fc_ready,
  output logic              fc_last,
  output logic              busy,
  output logic              err
);

  localparam int unsigned PIX_W  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TOTAL  = CH_NUM * PIX_NUM;

  flat_state_t       state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q [CH_NUM];
  logic [PIX_W-1:0]  pix_cnt_d [CH_NUM];
  logic [CH_NUM-1:0] done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              err_q, err_d;

  logic              wr_en, rd_en, in_range, last_idx, show;
  logic [3:0]        ch;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] rd_data;

  assign ch       = in_channel[3:0];
  assign in_range = ({27'd0, in_channel} < CH_NUM);
  assign wr_addr  = {ch, pix_cnt_q[ch]};
  assign show     = (state_q == ST_SHOW);
  assign last_idx = (rd_addr_q == ADDR_W'(TOTAL - 1));

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    done_d    = done_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (&done_q) begin
          state_d   = ST_READ;
          rd_addr_d = '0;
        end
        if (data_in_valid) begin
          if (!in_range || done_q[ch]) begin
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (pix_cnt_q[ch] == PIX_W'(PIX_NUM - 1)) begin
              pix_cnt_d[ch] = '0;
              done_d[ch]    = 1'b1;
            end else begin
              pix_cnt_d[ch] = pix_cnt_q[ch] + 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_SHOW;
        if (data_in_valid) err_d = 1'b1;
      end
      ST_SHOW: begin
        if (data_in_valid) err_d = 1'b1;
        if (fc_ready) begin
          if (last_idx) begin
            state_d = ST_FILL;
            done_d  = '0;
            for (int unsigned i = 0; i < CH_NUM; i++) pix_cnt_d[i] = '0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = ST_READ;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
    // Abort wins over every other event, including a pending buffer write.
    if (clear) begin
      state_d   = ST_FILL;
      done_d    = '0;
      rd_addr_d = '0;
      err_d     = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) pix_cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      done_q    <= '0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) pix_cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
    end
  end

  flat_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (TOTAL),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (data_in),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (rd_data)
  );

  assign fc_valid = show;
  assign fc_data  = show ? rd_data : '0;
  assign fc_index = show ? rd_addr_q : '0;
  assign fc_last  = show && last_idx;
  assign busy     = (state_q != ST_FILL);
  assign err      = err_q;

endmodule

// File: tb/tb_pool2_flatten.sv
// Directed bench for pool2_flatten: a reference model fills a frame image and
// queues the expected drain order; a monitor checks every handshake against it.
module tb_pool2_flatten;

  logic        clk = 1'b0;
  logic        rst_n, data_in_valid, clear, fc_ready;
  logic [15:0] data_in;
  logic [4:0]  in_channel;
  logic [15:0] fc_data;
  logic [7:0]  fc_index;
  logic        fc_valid, fc_last, busy, err;

  always #5 clk = ~clk;

  pool2_flatten #(.DATA_W(16), .CH_NUM(16), .PIX_NUM(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
    .in_channel(in_channel), .clear(clear), .fc_data(fc_data), .fc_index(fc_index),
    .fc_valid(fc_valid), .fc_ready(fc_ready), .fc_last(fc_last), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_mem  [256];
  logic [4:0]  m_cnt  [16];
  logic [15:0] m_done;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic clr_err);
    for (int i = 0; i < 16; i++) m_cnt[i] = '0;
    m_done = '0;
    if (clr_err) m_err = 1'b0;
  endtask

  task automatic send(input int ch, input logic [15:0] val);
    data_in       = val;
    in_channel    = 5'(ch);
    data_in_valid = 1'b1;
    if (ch >= 16 || m_done[ch]) begin
      m_err = 1'b1;
    end else begin
      m_mem[ch*16 + int'(m_cnt[ch])] = val;
      if (m_cnt[ch] == 5'd15) begin
        m_cnt[ch]  = '0;
        m_done[ch] = 1'b1;
      end else begin
        m_cnt[ch] = m_cnt[ch] + 5'd1;
      end
    end
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      e.idx  = 8'(i);
      e.data = m_mem[i];
      exp_q.push_back(e);
    end
    model_reset(1'b0);
  endtask

  task automatic fill_seq(input logic [15:0] base, input int extra_ch);
    for (int ch = 0; ch < 16; ch++) begin
      for (int p = 0; p < 16; p++) send(ch, base + 16'(ch*16 + p));
      if (ch == extra_ch) begin
        send(ch, 16'hDEAD);
        check("err_17th_sample", err, m_err);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, m_err);
  endtask

  task automatic wait_idx(input int idx, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(fc_valid && fc_index == 8'(idx)) && k < 2000);
    check({tag, "_reached"}, fc_index, 8'(idx));
  endtask

  always @(negedge clk) begin
    if (rst_n && fc_valid && fc_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(exp_q.size()), 32'd1);
      end else begin
        e_mon = exp_q.pop_front();
        check("fc_index", fc_index, e_mon.idx);
        check("fc_data", fc_data, e_mon.data);
        check("fc_last", fc_last, e_mon.idx == 8'd255);
      end
    end
  end

  initial begin
    int k;
    rst_n = 1'b0; data_in = '0; data_in_valid = 1'b0; in_channel = '0;
    clear = 1'b0; fc_ready = 1'b1;
    model_reset(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", fc_valid, 1'b0);
    check("rst_last", fc_last, 1'b0);
    check("rst_data", fc_data, 16'h0);
    check("rst_index", fc_index, 8'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential frame, value equals flat index
    fill_seq(16'h0000, -1);
    push_frame();
    wait_drain("seq");

    // Reverse round-robin interleave
    for (int p = 0; p < 16; p++)
      for (int ch = 15; ch >= 0; ch--) send(ch, 16'h2000 + 16'(ch*16 + p));
    push_frame();
    wait_drain("ilv");

    // Extra sample on channel 3, then backpressure at index 37
    check("err_before_17th", err, 1'b0);
    fill_seq(16'h3000, 3);
    push_frame();
    wait_idx(36, "stall");
    @(posedge clk); #1;
    fc_ready = 1'b0;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", fc_valid, 1'b1);
      check("hold_index", fc_index, 8'd37);
      check("hold_data", fc_data, m_mem[37]);
    end
    @(posedge clk); #1;
    fc_ready = 1'b1;
    wait_drain("stall");

    // Abort with clear while showing index 100
    fill_seq(16'h4000, -1);
    push_frame();
    wait_idx(99, "clr");
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    fc_ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    fc_ready = 1'b1;
    exp_q.delete();
    model_reset(1'b1);
    @(negedge clk);
    check("clr_valid", fc_valid, 1'b0);
    check("clr_busy", busy, 1'b0);
    check("clr_err", err, m_err);

    // Out-of-range channel, then a full frame after the abort
    send(20, 16'hBAD0);
    check("err_ch20", err, m_err);
    fill_seq(16'h5000, -1);
    push_frame();
    wait_drain("post_clr");

    // Reset mid-fill at channel 5 pixel 7
    for (int ch = 0; ch < 5; ch++)
      for (int p = 0; p < 16; p++) send(ch, 16'h6000 + 16'(ch*16 + p));
    for (int p = 0; p < 8; p++) send(5, 16'h6000 + 16'(80 + p));
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset(1'b1);
    check("mrst_valid", fc_valid, 1'b0);
    check("mrst_last", fc_last, 1'b0);
    check("mrst_data", fc_data, 16'h0);
    check("mrst_index", fc_index, 8'h0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_err", err, 1'b0);
    rst_n = 1'b1;

    // Full frame after reset, with an input injected during SHOW
    fill_seq(16'h7000, -1);
    push_frame();
    check("err_before_show_in", err, m_err);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fc_valid && k < 50);
    check("show_seen", fc_valid, 1'b1);
    data_in = 16'hBEEF; in_channel = 5'd2; data_in_valid = 1'b1;
    m_err = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    check("err_show_in", err, m_err);
    wait_drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
